// File: rtl/cnnpr_pkg.sv
// Shared widths, FSM encoding and small helpers for the sparse row processing element.
package cnnpr_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int IF_WIDTH     = 16;
    localparam int KERNEL_WIDTH = 3;
    localparam int OF_WIDTH     = IF_WIDTH - KERNEL_WIDTH + 1;
    localparam int ACC_WIDTH    = 24;
    localparam int PROD_WIDTH   = 2 * DATA_WIDTH;
    localparam int NUM_WEIGHTS  = KERNEL_WIDTH * KERNEL_WIDTH;
    localparam int IDX_WIDTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2,
        ST_DRAIN  = 2'd3
    } pe_state_e;

    // Kernel row 3 does not exist; it aliases the last row so the drain still triggers.
    function automatic logic [1:0] clamp_krow(input logic [1:0] k);
        logic [1:0] r;
        if (k == 2'd3) begin
            r = 2'd2;
        end else begin
            r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_mac3.sv
// Three signed 8x8 multipliers: one activation times the three taps of the selected kernel row.
module pe_mac3
    import cnnpr_pkg::*;
(
    input  logic [1:0]                               krow_sel,
    input  logic [DATA_WIDTH-1:0]                    act,
    input  logic [NUM_WEIGHTS*DATA_WIDTH-1:0]        weights,
    output logic [KERNEL_WIDTH-1:0][ACC_WIDTH-1:0]   prod
);

    logic [DATA_WIDTH-1:0] w_s [NUM_WEIGHTS];

    for (genvar i = 0; i < NUM_WEIGHTS; i++) begin : g_unpack
        assign w_s[i] = weights[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Tap k of row r is weight 3*r+k; 3*r is formed as r + 2*r.
    for (genvar k = 0; k < KERNEL_WIDTH; k++) begin : g_tap
        logic [3:0]                   wsel_s;
        logic signed [PROD_WIDTH-1:0] mult_s;
        assign wsel_s  = {2'b00, krow_sel} + {1'b0, krow_sel, 1'b0} + 4'(k);
        assign mult_s  = $signed(act) * $signed(w_s[wsel_s]);
        assign prod[k] = {{(ACC_WIDTH-PROD_WIDTH){mult_s[PROD_WIDTH-1]}}, mult_s};
    end

endmodule

// File: rtl/sparse_pe_row.sv
// Row-level sparse PE: accumulates a valid 1-D convolution over three kernel rows
// into 14 partial sums, then drains them through a valid/ready port.
module sparse_pe_row
    import cnnpr_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              row_start,
    input  logic [3:0]                        row_val_num,
    input  logic                              zero_flag,
    input  logic [1:0]                        krow,
    input  logic                              en,
    input  logic [DATA_WIDTH-1:0]             act_in,
    input  logic [IDX_WIDTH-1:0]              act_index,
    input  logic [NUM_WEIGHTS*DATA_WIDTH-1:0] parallel_in,
    input  logic                              psum_ready,
    output logic                              busy,
    output logic                              row_finish_done_0,
    output logic                              row_cal_done,
    output logic                              psum_valid,
    output logic [IDX_WIDTH-1:0]              psum_index,
    output logic [ACC_WIDTH-1:0]              psum_data
);

    pe_state_e             state_q, state_d;
    logic [1:0]            krow_q, krow_d;
    logic [3:0]            n_q, n_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [ACC_WIDTH-1:0]  acc_q [OF_WIDTH];
    logic [ACC_WIDTH-1:0]  acc_d [OF_WIDTH];

    logic                  busy_q, busy_d;
    logic                  row_finish_done_0_q, row_finish_done_0_d;
    logic                  row_cal_done_q, row_cal_done_d;
    logic                  psum_valid_q, psum_valid_d;
    logic [IDX_WIDTH-1:0]  psum_index_q, psum_index_d;
    logic [ACC_WIDTH-1:0]  psum_data_q, psum_data_d;

    logic [KERNEL_WIDTH-1:0][ACC_WIDTH-1:0] prod_s;

    pe_mac3 u_mac3 (
        .krow_sel (krow_q),
        .act      (act_in),
        .weights  (parallel_in),
        .prod     (prod_s)
    );

    // Next-state, accumulator update and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        krow_d  = krow_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        row_cal_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (row_start) begin
                    krow_d = clamp_krow(krow);
                    n_d    = row_val_num;
                    cnt_d  = 4'd0;
                    if (zero_flag) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (en) begin
                    // Column a feeds output o through tap k exactly when a == o + k.
                    for (int o = 0; o < OF_WIDTH; o++) begin
                        for (int k = 0; k < KERNEL_WIDTH; k++) begin
                            if (act_index == 4'(o + k)) begin
                                acc_d[o] = acc_d[o] + prod_s[k];
                            end else begin
                                acc_d[o] = acc_d[o];
                            end
                        end
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == n_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_FINISH: begin
                if (krow_q == 2'd2) begin
                    state_d = ST_DRAIN;
                    idx_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (psum_ready) begin
                    if (idx_q == 4'(OF_WIDTH - 1)) begin
                        for (int o = 0; o < OF_WIDTH; o++) begin
                            acc_d[o] = '0;
                        end
                        idx_d          = 4'd0;
                        state_d        = ST_IDLE;
                        row_cal_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d              = (state_d != ST_IDLE);
        row_finish_done_0_d = (state_d == ST_FINISH);
        psum_valid_d        = (state_d == ST_DRAIN);
        if (psum_valid_d) begin
            psum_index_d = idx_d;
            psum_data_d  = acc_q[idx_d];
        end else begin
            psum_index_d = 4'd0;
            psum_data_d  = '0;
        end
    end

    // State, accumulator and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= ST_IDLE;
            krow_q              <= 2'd0;
            n_q                 <= 4'd0;
            cnt_q               <= 4'd0;
            idx_q               <= 4'd0;
            for (int o = 0; o < OF_WIDTH; o++) begin
                acc_q[o] <= '0;
            end
            busy_q              <= 1'b0;
            row_finish_done_0_q <= 1'b0;
            row_cal_done_q      <= 1'b0;
            psum_valid_q        <= 1'b0;
            psum_index_q        <= 4'd0;
            psum_data_q         <= '0;
        end else begin
            state_q             <= state_d;
            krow_q              <= krow_d;
            n_q                 <= n_d;
            cnt_q               <= cnt_d;
            idx_q               <= idx_d;
            for (int o = 0; o < OF_WIDTH; o++) begin
                acc_q[o] <= acc_d[o];
            end
            busy_q              <= busy_d;
            row_finish_done_0_q <= row_finish_done_0_d;
            row_cal_done_q      <= row_cal_done_d;
            psum_valid_q        <= psum_valid_d;
            psum_index_q        <= psum_index_d;
            psum_data_q         <= psum_data_d;
        end
    end

    assign busy              = busy_q;
    assign row_finish_done_0 = row_finish_done_0_q;
    assign row_cal_done      = row_cal_done_q;
    assign psum_valid        = psum_valid_q;
    assign psum_index        = psum_index_q;
    assign psum_data         = psum_data_q;

endmodule

// File: tb/tb_sparse_pe_row.sv
// Scoreboard bench for sparse_pe_row: a column-arithmetic reference model queues
// the expected drain beats, and a monitor pops and compares them on each handshake.
module tb_sparse_pe_row;
    import cnnpr_pkg::*;

    logic        clk = 1'b0;
    logic        reset, row_start, zero_flag, en, psum_ready;
    logic [3:0]  row_val_num, act_index;
    logic [1:0]  krow;
    logic [7:0]  act_in;
    logic [71:0] parallel_in;
    logic        busy, row_finish_done_0, row_cal_done, psum_valid;
    logic [3:0]  psum_index;
    logic [23:0] psum_data;

    sparse_pe_row dut (
        .clk(clk), .reset(reset), .row_start(row_start), .row_val_num(row_val_num),
        .zero_flag(zero_flag), .krow(krow), .en(en), .act_in(act_in),
        .act_index(act_index), .parallel_in(parallel_in), .psum_ready(psum_ready),
        .busy(busy), .row_finish_done_0(row_finish_done_0), .row_cal_done(row_cal_done),
        .psum_valid(psum_valid), .psum_index(psum_index), .psum_data(psum_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] data;
    } beat_t;

    beat_t      exp_q[$];
    int         model_acc[14];
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;
    int         cal_count = 0;
    int         stall_left = 0;
    logic       rand_ready = 1'b0;
    logic [3:0] beat_idx[16];
    logic [7:0] beat_val[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: output o = sum over taps k of act[o+k] * w[3*row+k], summed over rows.
    task automatic model_beat(input logic [1:0] kr, input logic [3:0] a, input logic [7:0] v,
                              input logic [71:0] wts);
        for (int k = 0; k < 3; k++) begin
            int o;
            int wi;
            o  = int'(a) - k;
            wi = 3 * int'(kr) + k;
            if (o >= 0 && o <= 13) begin
                model_acc[o] += int'($signed(v)) * int'($signed(wts[8*wi +: 8]));
            end
        end
    endtask

    task automatic model_push();
        for (int o = 0; o < 14; o++) begin
            beat_t b;
            b.idx  = 4'(o);
            b.data = 24'(model_acc[o]);
            exp_q.push_back(b);
            model_acc[o] = 0;
        end
    endtask

    // Sink ready: always-ready, random, or a directed 5-cycle stall at index 3.
    always @(posedge clk) begin
        #1;
        if (psum_valid && psum_index == 4'd3 && stall_left > 0) begin
            psum_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            psum_ready = ($urandom_range(0, 3) != 0);
        end else begin
            psum_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard per handshake, checks hold-under-stall and row_cal_done timing.
    logic        prev_stalled = 1'b0;
    logic        hs13_prev = 1'b0;
    logic [3:0]  prev_idx;
    logic [23:0] prev_data;
    always @(negedge clk) begin
        if (reset) begin
            if (row_cal_done || hs13_prev) check("cal_done_timing", 32'(row_cal_done), 32'(hs13_prev));
            if (row_cal_done) cal_count++;
            hs13_prev = 1'b0;
            if (psum_valid) begin
                if (prev_stalled) begin
                    check("stall_idx_hold", 32'(psum_index), 32'(prev_idx));
                    check("stall_data_hold", 32'(psum_data), 32'(prev_data));
                end
                if (psum_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_psum_valid", 32'(psum_valid), 32'd0);
                    end else begin
                        beat_t b;
                        b = exp_q.pop_front();
                        check("psum_index", 32'(psum_index), 32'(b.idx));
                        check("psum_data", 32'(psum_data), 32'(b.data));
                    end
                    hs_count++;
                    hs13_prev = (psum_index == 4'd13);
                end
                prev_stalled = !psum_ready;
                prev_idx     = psum_index;
                prev_data    = psum_data;
            end else begin
                prev_stalled = 1'b0;
            end
        end else begin
            prev_stalled = 1'b0;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // One kernel row: row_start, beats with random gaps and ignored strobes, finish checks.
    task automatic run_row(input logic [1:0] kr, input logic zf, input int n, input logic [71:0] wts);
        logic [1:0] kr_eff;
        kr_eff = (kr == 2'd3) ? 2'd2 : kr;
        wait_idle();
        parallel_in = wts;
        row_start   = 1'b1;
        krow        = kr;
        zero_flag   = zf;
        row_val_num = zf ? 4'($urandom_range(0, 15)) : 4'(n - 1);
        en          = 1'b1;
        act_in      = 8'($urandom);
        act_index   = 4'($urandom);
        @(posedge clk); #1;
        row_start   = 1'b0;
        en          = 1'b0;
        krow        = 2'($urandom);
        row_val_num = 4'($urandom);
        zero_flag   = 1'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        if (zf) begin
            check("zero_row_finish", 32'(row_finish_done_0), 32'd1);
        end else begin
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    en        = 1'b0;
                    row_start = 1'($urandom);
                    act_in    = 8'($urandom);
                    act_index = 4'($urandom);
                    @(posedge clk); #1;
                end
                row_start = 1'b0;
                en        = 1'b1;
                act_in    = beat_val[b];
                act_index = beat_idx[b];
                model_beat(kr_eff, beat_idx[b], beat_val[b], wts);
                @(posedge clk); #1;
                if (b < n - 1) check("no_early_finish", 32'(row_finish_done_0), 32'd0);
            end
            en = 1'b0;
            check("finish_pulse", 32'(row_finish_done_0), 32'd1);
        end
        if (kr_eff == 2'd2) model_push();
        @(posedge clk); #1;
        check("finish_one_cycle", 32'(row_finish_done_0), 32'd0);
        if (kr_eff == 2'd2) begin
            check("drain_starts", 32'(psum_valid), 32'd1);
        end else begin
            check("idle_after_finish", 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_drain(input int hs_base, input int cal_base);
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("handshake_count", 32'(hs_count - hs_base), 32'd14);
        check("cal_done_count", 32'(cal_count - cal_base), 32'd1);
        check("idle_after_drain", 32'(busy), 32'd0);
    endtask

    task automatic rand_beats(input int n);
        for (int b = 0; b < n; b++) begin
            beat_idx[b] = 4'($urandom);
            beat_val[b] = 8'($urandom);
        end
    endtask

    task automatic group(input logic [1:0] last_kr, input logic [71:0] w0, input logic [71:0] w1,
                         input logic [71:0] w2, input int n0, input int n1, input int n2);
        int hb;
        int cb;
        rand_beats(n0); run_row(2'd0, n0 == 0, n0, w0);
        rand_beats(n1); run_row(2'd1, n1 == 0, n1, w1);
        hb = hs_count;
        cb = cal_count;
        rand_beats(n2); run_row(last_kr, n2 == 0, n2, w2);
        wait_drain(hb, cb);
    endtask

    initial begin
        logic [71:0] ones;
        logic [71:0] w;
        int hb;
        int cb;
        int t;
        ones = {9{8'h01}};
        for (int o = 0; o < 14; o++) model_acc[o] = 0;
        reset = 1'b0; row_start = 1'b1; en = 1'b1; zero_flag = 1'b0; krow = 2'd2;
        row_val_num = 4'd0; act_in = 8'h11; act_index = 4'd1; parallel_in = ones;
        psum_ready = 1'b1;

        // Reset held with live strobes.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_finish", 32'(row_finish_done_0), 32'd0);
            check("rst_cal", 32'(row_cal_done), 32'd0);
            check("rst_valid", 32'(psum_valid), 32'd0);
            check("rst_index", 32'(psum_index), 32'd0);
            check("rst_data", 32'(psum_data), 32'd0);
        end
        reset = 1'b1; row_start = 1'b0; en = 1'b0;

        // Basic krow=2 row with one beat.
        hb = hs_count; cb = cal_count;
        rand_beats(1);
        run_row(2'd2, 1'b0, 1, {$urandom, $urandom, $urandom});
        wait_drain(hb, cb);

        // Single activation 5 at column 2 with w6..w8 = 1,2,3.
        w = 72'd0; w[55:48] = 8'd1; w[63:56] = 8'd2; w[71:64] = 8'd3;
        beat_idx[0] = 4'd2; beat_val[0] = 8'd5;
        hb = hs_count; cb = cal_count;
        run_row(2'd2, 1'b0, 1, w);
        wait_drain(hb, cb);

        // Zero row on krow 0: no drain, idle two cycles after row_start.
        run_row(2'd0, 1'b1, 0, ones);

        // Three-row accumulation with the column 15 edge and a negative activation.
        beat_idx[0] = 4'd0; beat_val[0] = 8'd1;
        run_row(2'd0, 1'b0, 1, ones);
        run_row(2'd1, 1'b0, 1, ones);
        beat_idx[1] = 4'd15; beat_val[1] = 8'hFE;
        hb = hs_count; cb = cal_count;
        run_row(2'd2, 1'b0, 2, ones);
        wait_drain(hb, cb);

        // Backpressure: five stalled cycles at index 3.
        stall_left = 5;
        hb = hs_count; cb = cal_count;
        rand_beats(6);
        run_row(2'd2, 1'b0, 6, {$urandom, $urandom, $urandom});
        wait_drain(hb, cb);
        check("stall_consumed", 32'(stall_left), 32'd0);

        // Reset in the middle of a drain.
        rand_beats(4);
        run_row(2'd2, 1'b0, 4, {$urandom, $urandom, $urandom});
        t = 0;
        while (!(psum_valid && psum_index == 4'd7) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("reach_idx7_timeout", 32'(psum_index), 32'd7);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(psum_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // Full dense row after reset: every column active, all weights 1.
        for (int b = 0; b < 16; b++) begin
            beat_idx[b] = 4'(b);
            beat_val[b] = 8'd1;
        end
        hb = hs_count; cb = cal_count;
        run_row(2'd2, 1'b0, 16, ones);
        wait_drain(hb, cb);

        // Randomized row groups with random backpressure, krow=3 aliasing and zero rows.
        rand_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            group((g % 2 == 1) ? 2'd3 : 2'd2,
                  {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom},
                  (g == 2) ? 0 : $urandom_range(1, 16), $urandom_range(1, 16),
                  (g == 4) ? 0 : $urandom_range(1, 16));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
